// File: rtl/rf_scan_display.sv
// Register-file scanner: walks a read address across the CPU register file, captures each word
// and shows it on an 8-digit seven-segment display. Define RF_SCAN_IDX_DISP_EN to show the index.
module rf_scan_display #(
  parameter int unsigned SCAN_DIV  = 50_000_000,
  parameter int unsigned DIGIT_DIV = 100_000,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_i,
  input  logic        step_i,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [4:0]  cur_idx_o,
  output logic [7:0]  disp_an_o,
  output logic [7:0]  disp_seg_o
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned DigW  = (DIGIT_DIV > 2) ? $clog2(DIGIT_DIV) : 1;
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [DigW-1:0]  DigLast  = DigW'(DIGIT_DIV - 1);
  localparam logic [4:0]       LastReg  = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StHold} state_e;

  state_e            state_q, state_d;
  logic [4:0]        addr_q, addr_d;
  logic [4:0]        idx_q;
  logic [31:0]       word_q;
  logic [ScanW-1:0]  step_cnt_q, step_cnt_d;
  logic [DigW-1:0]   dig_cnt_q;
  logic [2:0]        ptr_q;
  logic [7:0]        an_q, seg_q, an_d, seg_d;
  logic              scan_en, manual, step_term, capture_en, advance;
  logic [31:0]       disp_word;
  logic [3:0]        nibble;
  logic              unused_sw;

  assign scan_en   = sw_i[15];
  assign manual    = sw_i[14];
  assign unused_sw = ^sw_i[13:0];
  assign step_term = (step_cnt_q == ScanLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (scan_en) state_d = StIssue;
      StIssue:   state_d = StCapture;
      // A capture in flight always completes; the switch only decides where it lands.
      StCapture: state_d = scan_en ? StHold : StIdle;
      StHold: begin
        if (!scan_en) begin
          state_d = StIdle;
        end else if (manual ? step_i : step_term) begin
          state_d = StIssue;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    capture_en = (state_q == StCapture);
    advance    = (state_q == StHold) && (state_d == StIssue);
    step_cnt_d = '0;
    if ((state_q == StHold) && scan_en && !manual && !step_term) begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
    addr_d = addr_q;
    if (advance) begin
      addr_d = (addr_q == LastReg) ? 5'd0 : addr_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      step_cnt_q <= '0;
    end else begin
      addr_q     <= addr_d;
      step_cnt_q <= step_cnt_d;
      if (capture_en) begin
        word_q <= rf_data_i;
        idx_q  <= addr_q;
      end
    end
  end

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  always_comb begin
`ifdef RF_SCAN_IDX_DISP_EN
    disp_word = {3'b000, idx_q, word_q[23:0]};
`else
    disp_word = word_q;
`endif
    nibble = 4'(disp_word >> {ptr_q, 2'b00});
    an_d   = ~(8'h01 << ptr_q);
    seg_d  = hex_seg(nibble);
`ifdef RF_SCAN_IDX_DISP_EN
    // Decimal point after the index digits separates index from data.
    if (ptr_q == 3'd6) seg_d[7] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_cnt_q <= '0;
      ptr_q     <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 8'hFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      if (dig_cnt_q == DigLast) begin
        dig_cnt_q <= '0;
        ptr_q     <= ptr_q + 3'd1;
      end else begin
        dig_cnt_q <= dig_cnt_q + 1'b1;
      end
    end
  end

  assign rf_addr_o  = addr_q;
  assign cur_idx_o  = idx_q;
  assign disp_an_o  = an_q;
  assign disp_seg_o = seg_q;

endmodule

// File: tb/tb_rf_scan_display.sv
// Scoreboard bench for rf_scan_display: captures and display digits are checked by monitors
// against expectations queued by the stimulus.
module tb_rf_scan_display;

  typedef struct {logic [4:0] idx; int gap;} idx_exp_t;
  typedef struct {logic [7:0] an; logic [7:0] seg;} disp_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw = '0;
  logic        step = 1'b0;
  logic [4:0]  rf_addr, cur_idx, rf_addr8, cur_idx8;
  logic [31:0] rf_data, rf_data8;
  logic [7:0]  disp_an, disp_seg, an8_unused, seg8_unused;
  logic        use_fixed = 1'b0;
  logic [31:0] fixed_word = '0;
  logic        sb_en = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic [4:0] prev_idx = '0;
  logic [4:0] prev_idx8 = '0;
  logic [4:0] exp8 = '0;
  logic [7:0] prev_an = 8'hFF;
  idx_exp_t  sb_q[$];
  disp_exp_t disp_q[$];
  logic [7:0] exp_seg [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign rf_data  = use_fixed ? fixed_word : {27'h0, rf_addr} + 32'h100;
  assign rf_data8 = {27'h0, rf_addr8} + 32'h100;

  rf_scan_display #(.SCAN_DIV(4), .DIGIT_DIV(2), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .sw_i(sw), .step_i(step), .rf_addr_o(rf_addr), .rf_data_i(rf_data),
    .cur_idx_o(cur_idx), .disp_an_o(disp_an), .disp_seg_o(disp_seg)
  );

  rf_scan_display #(.SCAN_DIV(4), .DIGIT_DIV(2), .NUM_REGS(8)) dut8 (
    .clk(clk), .rst(rst), .sw_i(sw), .step_i(step), .rf_addr_o(rf_addr8),
    .rf_data_i(rf_data8), .cur_idx_o(cur_idx8), .disp_an_o(an8_unused),
    .disp_seg_o(seg8_unused)
  );

  // Capture monitor: every change of the displayed index is one capture.
  always @(negedge clk) begin
    if (sb_en && cur_idx !== prev_idx) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL idx_unexpected: got idx=%0d, required no capture", cur_idx);
      end else begin
        idx_exp_t e;
        e = sb_q.pop_front();
        if (cur_idx !== e.idx || (e.gap != 0 && (cyc - last_cyc) != e.gap)) begin
          errors++;
          $display("FAIL idx_seq: got idx=%0d gap=%0d, required idx=%0d gap=%0d",
                   cur_idx, cyc - last_cyc, e.idx, e.gap);
        end
      end
      last_cyc = cyc;
    end
    prev_idx = cur_idx;
  end

  // Eight-register instance: each capture must be the successor modulo 8.
  always @(negedge clk) begin
    if (rst) begin
      exp8 = '0;
    end else if (sb_en && cur_idx8 !== prev_idx8) begin
      exp8 = (exp8 == 5'd7) ? 5'd0 : exp8 + 5'd1;
      checks++;
      if (cur_idx8 !== exp8 || rf_addr8 > 5'd7) begin
        errors++;
        $display("FAIL wrap8: got idx=%0d addr=%0d, required idx=%0d addr<=7",
                 cur_idx8, rf_addr8, exp8);
      end
    end
    prev_idx8 = cur_idx8;
  end

  // Display monitor: compares each new digit while expectations are pending.
  always @(negedge clk) begin
    if (disp_q.size() != 0 && disp_an !== prev_an) begin
      disp_exp_t d;
      d = disp_q.pop_front();
      checks++;
      if (disp_an !== d.an || disp_seg !== d.seg) begin
        errors++;
        $display("FAIL disp_digit: got an=%h seg=%h, required an=%h seg=%h",
                 disp_an, disp_seg, d.an, d.seg);
      end
    end
    prev_an = disp_an;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic wait_sb(input int budget, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d captures outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic push_idx(input logic [4:0] idx, input int gap);
    idx_exp_t e;
    e.idx = idx;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic pulse_step(input int len);
    repeat (3) @(negedge clk);
    step = 1'b1;
    repeat (len) @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
`ifdef RF_SCAN_IDX_DISP_EN
    exp_seg = '{8'h92, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'h12, 8'hC0};
`else
    exp_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
`endif
    #1 rst = 1'b1;
    #2;
    chk("reset_addr", {27'h0, rf_addr}, 32'h0);
    chk("reset_idx", {27'h0, cur_idx}, 32'h0);
    chk("reset_an", {24'h0, disp_an}, 32'hFF);
    chk("reset_seg", {24'h0, disp_seg}, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_en = 1'b1;

    // Auto scan through the whole file, across the wrap and on to register 7.
    for (int i = 1; i < 32; i++) push_idx(5'(i), (i == 1) ? 0 : 6);
    push_idx(5'd0, 6);
    for (int i = 1; i < 8; i++) push_idx(5'(i), 6);
    sw = 16'h8000;
    wait_sb(400, "auto_scan");

    // Asynchronous reset between edges while holding register 7.
    chk("pre_reset_addr", {27'h0, rf_addr}, 32'h7);
    sb_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_addr", {27'h0, rf_addr}, 32'h0);
    chk("async_rst_idx", {27'h0, cur_idx}, 32'h0);
    chk("async_rst_an", {24'h0, disp_an}, 32'hFF);
    chk("async_rst_seg", {24'h0, disp_seg}, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    sw = 16'hC000;
    rst = 1'b0;
    sb_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("manual_no_auto", {27'h0, cur_idx}, 32'h0);

    // Step held through ISSUE and CAPTURE advances only once.
    push_idx(5'd1, 0);
    pulse_step(3);
    wait_sb(10, "manual_step1");
    repeat (100) @(negedge clk);
    chk("manual_idle_100", {27'h0, cur_idx}, 32'h1);
    chk("manual_addr", {27'h0, rf_addr}, 32'h1);
    for (int i = 2; i < 5; i++) begin
      push_idx(5'(i), 0);
      pulse_step(1);
      wait_sb(10, "manual_step");
    end
`ifndef RF_SCAN_IDX_DISP_EN
    use_fixed = 1'b1;
    fixed_word = 32'h1234ABCD;
`endif
    push_idx(5'd5, 0);
    pulse_step(1);
    wait_sb(10, "manual_step5");
    sw = 16'h0000;
    repeat (3) @(negedge clk);
    // File contents change after capture; the display must not follow.
    use_fixed = 1'b1;
    fixed_word = 32'hFFFF_FFFF;
    repeat (5) @(negedge clk);

    begin
      int n = 0;
      while (disp_an !== 8'h7F && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("disp_sync", {24'h0, disp_an}, 32'h7F);
    end
    #1;
    for (int p = 0; p < 8; p++) begin
      disp_exp_t d;
      d.an = ~(8'h01 << p);
      d.seg = exp_seg[p];
      disp_q.push_back(d);
    end
    begin
      int n = 0;
      while (disp_q.size() != 0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (disp_q.size() != 0) begin
        errors++;
        $display("FAIL disp_walk: got %0d digits outstanding, required 0", disp_q.size());
        disp_q.delete();
      end
    end
    chk("idle_addr_kept", {27'h0, rf_addr}, 32'h5);
    chk("idle_idx_kept", {27'h0, cur_idx}, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_scan_display.md
Name: rf_scan_display

Overview:
- Read-side debug companion to the CPU register file.
- Walks a 5-bit read address across the register file through a dedicated read port and captures the 32-bit word returned.
- Shows the captured word on the 8-digit multiplexed seven-segment display.
- Steps either automatically at a programmable rate or one register per debounced step pulse; switch-controlled, so a register dump can be read on the board without halting the datapath.

Parameters:
- SCAN_DIV, 50_000_000, clk cycles between automatic register steps (≥4)
- DIGIT_DIV, 100_000, clk cycles each display digit is driven before advancing (≥2)
- NUM_REGS, 32, number of registers scanned; index wraps NUM_REGS-1 -> 0 (2..32)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- sw_i  in  16  sw_i[15]=scan enable, sw_i[14]=manual mode, other bits ignored
- step_i  in  1  single-cycle pulse, already debounced; manual step request
- rf_addr_o  out  5  register-file read address (drives an A1/A2-style combinational read port)
- rf_data_i  in  32  combinational read data for rf_addr_o
- cur_idx_o  out  5  index of the word currently held for display
- disp_an_o  out  8  digit enables, active low, bit 0 = rightmost digit
- disp_seg_o  out  8  segments {dp,g,f,e,d,c,b,a}, active low

Behaviour:
Reset (async, rst=1):
- rf_addr_o=0, cur_idx_o=0, captured word=0.
- disp_an_o=8'hFF, disp_seg_o=8'hFF.
- Step counter, digit counter and digit pointer = 0.
- FSM = IDLE.

FSM states:
- IDLE: no scanning. Display keeps refreshing the last captured word. Go to ISSUE when sw_i[15]=1.
- ISSUE: rf_addr_o already holds the target index. Go to CAPTURE next cycle.
- CAPTURE: register rf_data_i into the capture register and set cur_idx_o=rf_addr_o. Go to HOLD. Capture occurs exactly one cycle after the address is stable.
- HOLD, auto mode (sw_i[14]=0): step counter counts to SCAN_DIV-1. On the terminal count, rf_addr_o advances and the FSM goes to ISSUE.
- HOLD, manual mode (sw_i[14]=1): step counter is held at 0. step_i=1 advances rf_addr_o and the FSM goes to ISSUE.
- HOLD, any mode: sw_i[15]=0 returns to IDLE. rf_addr_o and the captured word are retained.

Address arithmetic:
- Next address = (rf_addr_o == NUM_REGS-1) ? 0 : rf_addr_o+1.
- Never exceeds NUM_REGS-1.

Boundary and simultaneous events:
- step_i in any state other than HOLD is ignored; it is not queued.
- step_i in auto mode is ignored.
- A mode switch in HOLD clears the step counter in the same cycle.
- sw_i[15] falling in ISSUE or CAPTURE: the capture still completes, then the FSM goes to IDLE instead of HOLD.
- Register 0 is scanned and displays 00000000. Read data is taken as-is from the port.
- Captured data changing in the file after capture does not update the display until the next capture.

Display multiplexing:
- Independent of the FSM; runs in every state after reset.
- Digit counter wraps at DIGIT_DIV-1. On wrap, the digit pointer p increments mod 8.
- disp_an_o = ~(1<<p), registered.
- disp_seg_o encodes nibble p of the displayed word, registered in the same cycle as disp_an_o.
- Hex map: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- dp is always off (bit7=1).

Latency:
- Address change to captured word: 2 cycles.
- Captured word to visible digit: at most 8*DIGIT_DIV cycles.

Optional Feature:
Macro RF_SCAN_IDX_DISP_EN.
- Defined: digits 7..6 show cur_idx_o as two hex digits (0x00–0x1F) and digits 5..0 show captured word bits [23:0]. dp on digit 6 is lit as a separator (disp_seg_o bit7=0 when p=6).
- Undefined: all 8 digits show the full 32-bit word and dp is never lit.

Test Plan:
- Parameters: SCAN_DIV=4, DIGIT_DIV=2, NUM_REGS=32. The RF model returns rf_data_i = {27'h0, rf_addr_o}+32'h100.
1. Reset mid-HOLD with rf_addr_o=7: assert rst asynchronously between edges -> rf_addr_o=0, cur_idx_o=0, disp_an_o=FF, disp_seg_o=FF immediately, before the next edge.
2. Auto scan: sw_i=16'h8000 -> cur_idx_o steps 0,1,2 with captures 0x100,0x101,0x102; consecutive steps exactly 6 cycles apart (ISSUE+CAPTURE+4 HOLD).
3. Wrap: auto scan from index 31 -> captures 0x11F, then rf_addr_o=0, capture 0x100. NUM_REGS=8 variant wraps 7->0.
4. Manual mode: sw_i=16'hC000, step_i pulsed in HOLD -> exactly one advance per pulse; pulses in ISSUE/CAPTURE are ignored; no auto advance over 100 cycles.
5. Display: captured 32'h1234ABCD, macro undefined -> over 16 cycles, disp_an_o walks FE,FD,…,7F and disp_seg_o shows A1,C6,83,88,99,B0,A4,F9.
6. Macro defined, cur_idx_o=5, word 0x00000105 -> digits 7..0 show 0,5,0,0,0,1,0,5; at p=6 disp_seg_o=8'h12 (5 with dp lit).
